// File: rtl/conv_window_feeder_if.sv
// Pixel-stream in / 3x3-window out bus between greyscale, the window feeder and convolution.
// The master modport is the feeder side; slave is the upstream/downstream environment.
interface conv_window_feeder_if #(
  parameter int unsigned DATA_W = 12
);
  localparam int unsigned WIN_W = 9 * DATA_W;

  logic              iSOF;
  logic              iDVAL;
  logic [DATA_W-1:0] iDATA;
  logic [WIN_W-1:0]  data_out;
  logic              start;
  logic [15:0]       oX;
  logic [15:0]       oY;
  logic              frame_done;

  modport master (
    input  iSOF, iDVAL, iDATA,
    output data_out, start, oX, oY, frame_done
  );

  modport slave (
    output iSOF, iDVAL, iDATA,
    input  data_out, start, oX, oY, frame_done
  );
endinterface

// File: rtl/conv_window_feeder.sv
// Buffers two raster lines and issues every interior 3x3 neighbourhood as a packed
// window, one cycle after its bottom-right pixel is accepted, with a one-cycle start pulse.
module conv_window_feeder #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned IMG_W  = 640,
  parameter int unsigned IMG_H  = 480
) (
  input  logic                  clk,
  input  logic                  rst_n,
  conv_window_feeder_if.master  bus
);

  localparam int unsigned CW    = 16;
  localparam int unsigned AW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned WIN_W = 9 * DATA_W;
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [CW-1:0] LAST_ROW = CW'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_e;

  state_e            state_q;
  logic [CW-1:0]     col_q;
  logic [CW-1:0]     row_q;
  logic [WIN_W-1:0]  data_out_q;
  logic              start_q;
  logic [CW-1:0]     ox_q;
  logic [CW-1:0]     oy_q;
  logic              frame_done_q;

  // Line buffers (lb1 = row y-1, lb2 = row y-2) and the two previous window columns.
  logic [DATA_W-1:0] lb1_q [IMG_W];
  logic [DATA_W-1:0] lb2_q [IMG_W];
  logic [DATA_W-1:0] win_q [3][2];

  logic              accept_c;
  logic              wrap_c;
  logic              last_c;
  logic              issue_c;
  logic [CW-1:0]     cur_col_c;
  logic [CW-1:0]     cur_row_c;
  logic [AW-1:0]     idx_c;
  logic [DATA_W-1:0] new_col_c [3];
  logic [WIN_W-1:0]  window_c;

  // iSOF restarts the frame in the same cycle, so a coincident pixel lands at (0,0).
  always_comb begin
    cur_col_c    = bus.iSOF ? '0 : col_q;
    cur_row_c    = bus.iSOF ? '0 : row_q;
    accept_c     = bus.iDVAL && (bus.iSOF || (state_q == FILL) || (state_q == STREAM));
    idx_c        = cur_col_c[AW-1:0];
    new_col_c[0] = lb2_q[idx_c];
    new_col_c[1] = lb1_q[idx_c];
    new_col_c[2] = bus.iDATA;
    wrap_c       = (cur_col_c == LAST_COL);
    last_c       = wrap_c && (cur_row_c == LAST_ROW);
    issue_c      = accept_c && (cur_col_c >= CW'(2)) && (cur_row_c >= CW'(2));
    window_c     = '0;
    for (int r = 0; r < 3; r++) begin
      window_c[DATA_W*(3*r+0) +: DATA_W] = win_q[r][0];
      window_c[DATA_W*(3*r+1) +: DATA_W] = win_q[r][1];
      window_c[DATA_W*(3*r+2) +: DATA_W] = new_col_c[r];
    end
  end

  // Frame FSM, raster counters and registered window outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      data_out_q   <= '0;
      start_q      <= 1'b0;
      ox_q         <= '0;
      oy_q         <= '0;
      frame_done_q <= 1'b0;
    end else begin
      start_q <= issue_c;
      if (bus.iSOF) begin
        state_q      <= FILL;
        col_q        <= '0;
        row_q        <= '0;
        frame_done_q <= 1'b0;
      end
      if (accept_c) begin
        col_q <= wrap_c ? '0 : cur_col_c + CW'(1);
        if (wrap_c) begin
          row_q <= cur_row_c + CW'(1);
        end
        if (last_c) begin
          state_q      <= DONE;
          frame_done_q <= 1'b1;
        end else if (wrap_c && (cur_row_c == CW'(1))) begin
          state_q <= STREAM;
        end
      end
      if (issue_c) begin
        data_out_q <= window_c;
        ox_q       <= cur_col_c - CW'(1);
        oy_q       <= cur_row_c - CW'(1);
      end
    end
  end

  // Pixel storage needs no reset: windows are only issued once it holds frame data.
  always_ff @(posedge clk) begin
    if (accept_c) begin
      lb2_q[idx_c] <= lb1_q[idx_c];
      lb1_q[idx_c] <= bus.iDATA;
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= new_col_c[r];
      end
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.start      = start_q;
  assign bus.oX         = ox_q;
  assign bus.oY         = oy_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Bench for conv_window_feeder on an 8x6 image: a frame-image reference model predicts
// every window, its coordinates and frame_done cycle by cycle.
module tb_conv_window_feeder;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int DW = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_window_feeder_if #(.DATA_W(DW)) bus ();

  conv_window_feeder #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int nchk = 0;
  int nerr = 0;

  // Reference model: the pixels of the current frame plus the raster position.
  logic [DW-1:0]   img [H][W];
  bit              m_armed = 1'b0;
  bit              m_done  = 1'b0;
  int              m_x = 0;
  int              m_y = 0;
  logic            e_start = 1'b0;
  logic [15:0]     e_ox = '0;
  logic [15:0]     e_oy = '0;
  logic [9*DW-1:0] e_win = '0;

  // Drive one cycle, advance the model, then settle just past the clock edge.
  task automatic cycle(input logic sof, input logic dval, input logic [DW-1:0] data);
    bit acc;
    bus.iSOF  = sof;
    bus.iDVAL = dval;
    bus.iDATA = data;
    acc = dval && (sof || m_armed);
    if (sof) begin
      m_armed = 1'b1; m_x = 0; m_y = 0; m_done = 1'b0;
    end
    e_start = 1'b0;
    if (acc) begin
      img[m_y][m_x] = data;
      if (m_x >= 2 && m_y >= 2) begin
        e_start = 1'b1;
        e_ox = 16'(m_x - 1);
        e_oy = 16'(m_y - 1);
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            e_win[DW*(3*r+c) +: DW] = img[m_y-2+r][m_x-2+c];
      end
      if (m_x == W - 1) begin
        m_x = 0;
        if (m_y == H - 1) begin
          m_armed = 1'b0; m_done = 1'b1;
        end else m_y++;
      end else m_x++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.iSOF = 1'b0; bus.iDVAL = 1'b0; bus.iDATA = '0;
    repeat (2) @(posedge clk);
    #1;
    nchk++;
    if ({bus.start, bus.oX, bus.oY, bus.frame_done, bus.data_out} !== '0) begin
      nerr++;
      $display("FAIL reset_state: got start=%b oX=%0d oY=%0d done=%b win=%h; want all zero",
               bus.start, bus.oX, bus.oY, bus.frame_done, bus.data_out);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_reset_and_arming();
    cycle(1'b1, 1'b0, '0);
    for (int p = 0; p < 30; p++) begin
      cycle(1'b0, 1'b1, DW'($urandom));
      nchk++;
      if ({bus.start, bus.oX, bus.oY, bus.frame_done, bus.data_out} !== {e_start, e_ox, e_oy, m_done, e_win}) begin
        nerr++;
        $display("FAIL pre_reset: got start=%b oX=%0d oY=%0d done=%b win=%h; want start=%b oX=%0d oY=%0d done=%b win=%h",
                 bus.start, bus.oX, bus.oY, bus.frame_done, bus.data_out, e_start, e_ox, e_oy, m_done, e_win);
      end
    end
    rst_n = 1'b0;
    #1;
    nchk++;
    if ({bus.start, bus.oX, bus.oY, bus.frame_done, bus.data_out} !== '0) begin
      nerr++;
      $display("FAIL async_reset: got start=%b oX=%0d oY=%0d done=%b win=%h; want all zero",
               bus.start, bus.oX, bus.oY, bus.frame_done, bus.data_out);
    end
    m_armed = 1'b0; m_done = 1'b0; e_start = 1'b0; e_ox = '0; e_oy = '0; e_win = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int p = 0; p < 24; p++) begin
      cycle(1'b0, 1'b1, DW'($urandom));
      nchk++;
      if ({bus.start, bus.frame_done, bus.data_out} !== {1'b0, 1'b0, {9*DW{1'b0}}}) begin
        nerr++;
        $display("FAIL unarmed: got start=%b done=%b win=%h; want start=0 done=0 win=0",
                 bus.start, bus.frame_done, bus.data_out);
      end
    end
  endtask

  task automatic test_ramp_continuous();
    int pulses = 0;
    int vals [9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
    logic [9*DW-1:0] first_w;
    logic [15:0] last_x = '0;
    logic [15:0] last_y = '0;
    for (int k = 0; k < 9; k++) first_w[DW*k +: DW] = DW'(vals[k]);
    for (int p = 0; p < W*H; p++) begin
      cycle(p == 0, 1'b1, DW'(p));
      nchk++;
      if ({bus.start, bus.oX, bus.oY, bus.frame_done, bus.data_out} !== {e_start, e_ox, e_oy, m_done, e_win}) begin
        nerr++;
        $display("FAIL ramp_cont p=%0d: got start=%b oX=%0d oY=%0d done=%b win=%h; want start=%b oX=%0d oY=%0d done=%b win=%h",
                 p, bus.start, bus.oX, bus.oY, bus.frame_done, bus.data_out, e_start, e_ox, e_oy, m_done, e_win);
      end
      if (bus.start === 1'b1) begin
        if (pulses == 0) begin
          nchk++;
          if ({bus.oX, bus.oY, bus.data_out} !== {16'd1, 16'd1, first_w}) begin
            nerr++;
            $display("FAIL first_window: got oX=%0d oY=%0d win=%h; want oX=1 oY=1 win=%h",
                     bus.oX, bus.oY, bus.data_out, first_w);
          end
        end
        pulses++;
        last_x = bus.oX; last_y = bus.oY;
      end
    end
    nchk++;
    if (pulses != 24 || last_x != 16'd6 || last_y != 16'd4) begin
      nerr++;
      $display("FAIL ramp_count: got pulses=%0d last=(%0d,%0d); want pulses=24 last=(6,4)", pulses, last_x, last_y);
    end
    nchk++;
    if (bus.frame_done !== 1'b1) begin
      nerr++;
      $display("FAIL frame_done_set: got %b want 1", bus.frame_done);
    end
  endtask

  task automatic test_ramp_gaps();
    int pulses = 0;
    logic prev = 1'b0;
    cycle(1'b1, 1'b0, '0);
    for (int i = 0; i < 3*W*H; i++) begin
      cycle(1'b0, (i % 3) == 0, (i % 3) == 0 ? DW'(i / 3) : DW'($urandom));
      nchk++;
      if ({bus.start, bus.oX, bus.oY, bus.frame_done, bus.data_out} !== {e_start, e_ox, e_oy, m_done, e_win}) begin
        nerr++;
        $display("FAIL ramp_gaps i=%0d: got start=%b oX=%0d oY=%0d done=%b win=%h; want start=%b oX=%0d oY=%0d done=%b win=%h",
                 i, bus.start, bus.oX, bus.oY, bus.frame_done, bus.data_out, e_start, e_ox, e_oy, m_done, e_win);
      end
      nchk++;
      if (prev === 1'b1 && bus.start === 1'b1) begin
        nerr++;
        $display("FAIL gap_consecutive i=%0d: got start=1 twice; want isolated pulses", i);
      end
      prev = bus.start;
      if (bus.start === 1'b1) pulses++;
    end
    nchk++;
    if (pulses != 24) begin
      nerr++;
      $display("FAIL gaps_count: got %0d want 24", pulses);
    end
  endtask

  task automatic test_sof_mid_frame();
    int pulses = 0;
    cycle(1'b1, 1'b0, '0);
    for (int p = 0; p < 3*W + 4; p++) cycle(1'b0, 1'b1, DW'($urandom));
    cycle(1'b1, 1'b0, '0);
    for (int p = 0; p < W*H; p++) begin
      cycle(1'b0, 1'b1, DW'(p));
      nchk++;
      if ({bus.start, bus.oX, bus.oY, bus.frame_done, bus.data_out} !== {e_start, e_ox, e_oy, m_done, e_win}) begin
        nerr++;
        $display("FAIL sof_mid p=%0d: got start=%b oX=%0d oY=%0d done=%b win=%h; want start=%b oX=%0d oY=%0d done=%b win=%h",
                 p, bus.start, bus.oX, bus.oY, bus.frame_done, bus.data_out, e_start, e_ox, e_oy, m_done, e_win);
      end
      if (bus.start === 1'b1) pulses++;
    end
    nchk++;
    if (pulses != 24) begin
      nerr++;
      $display("FAIL sof_mid_count: got %0d want 24", pulses);
    end
  endtask

  task automatic test_after_done_and_sof_dval();
    bit seen = 1'b0;
    for (int p = 0; p < 10; p++) begin
      cycle(1'b0, 1'b1, DW'($urandom));
      nchk++;
      if ({bus.start, bus.frame_done} !== 2'b01) begin
        nerr++;
        $display("FAIL post_done: got start=%b done=%b; want start=0 done=1", bus.start, bus.frame_done);
      end
    end
    for (int p = 0; p < W*H; p++) begin
      cycle(p == 0, 1'b1, p == 0 ? DW'(12'h5A5) : DW'(p));
      nchk++;
      if ({bus.start, bus.oX, bus.oY, bus.frame_done, bus.data_out} !== {e_start, e_ox, e_oy, m_done, e_win}) begin
        nerr++;
        $display("FAIL sof_dval p=%0d: got start=%b oX=%0d oY=%0d done=%b win=%h; want start=%b oX=%0d oY=%0d done=%b win=%h",
                 p, bus.start, bus.oX, bus.oY, bus.frame_done, bus.data_out, e_start, e_ox, e_oy, m_done, e_win);
      end
      if (bus.start === 1'b1 && !seen) begin
        seen = 1'b1;
        nchk++;
        if (bus.data_out[DW-1:0] !== 12'h5A5) begin
          nerr++;
          $display("FAIL sof_pixel_field0: got %h want 5a5", bus.data_out[DW-1:0]);
        end
      end
    end
  endtask

  task automatic test_back_to_back_saturated();
    int pulses = 0;
    logic [9*DW-1:0] ones = '1;
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < W*H; p++) begin
        cycle(p == 0, 1'b1, 12'hFFF);
        nchk++;
        if ({bus.start, bus.oX, bus.oY, bus.frame_done} !== {e_start, e_ox, e_oy, m_done}) begin
          nerr++;
          $display("FAIL sat f=%0d p=%0d: got start=%b oX=%0d oY=%0d done=%b; want start=%b oX=%0d oY=%0d done=%b",
                   f, p, bus.start, bus.oX, bus.oY, bus.frame_done, e_start, e_ox, e_oy, m_done);
        end
        if (bus.start === 1'b1) begin
          pulses++;
          nchk++;
          if (bus.data_out !== ones) begin
            nerr++;
            $display("FAIL sat_window f=%0d p=%0d: got %h want all fff", f, p, bus.data_out);
          end
        end
      end
    end
    nchk++;
    if (pulses != 48) begin
      nerr++;
      $display("FAIL sat_count: got %0d want 48", pulses);
    end
  endtask

  task automatic test_random_gaps();
    int pulses = 0;
    int p = 0;
    cycle(1'b1, 1'b0, '0);
    while (p < W*H) begin
      logic dv;
      dv = ($urandom_range(0, 2) == 0);
      cycle(1'b0, dv, DW'($urandom));
      if (dv) p++;
      nchk++;
      if ({bus.start, bus.oX, bus.oY, bus.frame_done, bus.data_out} !== {e_start, e_ox, e_oy, m_done, e_win}) begin
        nerr++;
        $display("FAIL rand_gaps p=%0d: got start=%b oX=%0d oY=%0d done=%b win=%h; want start=%b oX=%0d oY=%0d done=%b win=%h",
                 p, bus.start, bus.oX, bus.oY, bus.frame_done, bus.data_out, e_start, e_ox, e_oy, m_done, e_win);
      end
      if (bus.start === 1'b1) pulses++;
    end
    nchk++;
    if (pulses != 24) begin
      nerr++;
      $display("FAIL rand_count: got %0d want 24", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_reset_and_arming();
    test_ramp_continuous();
    test_ramp_gaps();
    test_sof_mid_frame();
    test_after_done_and_sof_dval();
    test_back_to_back_saturated();
    test_random_gaps();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
